// File: rtl/mux_display_decoder_pkg.sv
// Shared definitions for the multiplexed 7-segment display checkers.
// Provides the segment bit positions (A..G on bits 0..6), the active-high
// segment patterns for hex digits 0..F, and the default digit count.
package mux_display_decoder_pkg;

  localparam int DEFAULT_NUM_DIGITS = 4;

  // Segment bit positions within a 7-bit pattern
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] M_A = 7'(1 << SEG_A);
  localparam logic [6:0] M_B = 7'(1 << SEG_B);
  localparam logic [6:0] M_C = 7'(1 << SEG_C);
  localparam logic [6:0] M_D = 7'(1 << SEG_D);
  localparam logic [6:0] M_E = 7'(1 << SEG_E);
  localparam logic [6:0] M_F = 7'(1 << SEG_F);
  localparam logic [6:0] M_G = 7'(1 << SEG_G);

  // Hex glyphs built from lit segments (0x3F, 0x06, 0x5B, ... 0x71)
  localparam logic [6:0] SEG_0 = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [6:0] SEG_1 = M_B | M_C;
  localparam logic [6:0] SEG_2 = M_A | M_B | M_D | M_E | M_G;
  localparam logic [6:0] SEG_3 = M_A | M_B | M_C | M_D | M_G;
  localparam logic [6:0] SEG_4 = M_B | M_C | M_F | M_G;
  localparam logic [6:0] SEG_5 = M_A | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG_6 = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_7 = M_A | M_B | M_C;
  localparam logic [6:0] SEG_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_9 = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG_A_GLYPH = M_A | M_B | M_C | M_E | M_F | M_G;
  localparam logic [6:0] SEG_B_GLYPH = M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_C_GLYPH = M_A | M_D | M_E | M_F;
  localparam logic [6:0] SEG_D_GLYPH = M_B | M_C | M_D | M_E | M_G;
  localparam logic [6:0] SEG_E_GLYPH = M_A | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_F_GLYPH = M_A | M_E | M_F | M_G;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment to hex decoder.
// Ports:
//   seg    - active-high segment pattern, bit0 = A ... bit6 = G
//   nibble - decoded hex value (0 when the pattern is not a hex glyph)
//   bad    - 1 when the pattern matches none of the 16 hex glyphs
module seg7_to_hex
  import mux_display_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       bad
);

  always_comb begin
    nibble = 4'h0;
    bad    = 1'b0;
    case (seg)
      SEG_0:       nibble = 4'h0;
      SEG_1:       nibble = 4'h1;
      SEG_2:       nibble = 4'h2;
      SEG_3:       nibble = 4'h3;
      SEG_4:       nibble = 4'h4;
      SEG_5:       nibble = 4'h5;
      SEG_6:       nibble = 4'h6;
      SEG_7:       nibble = 4'h7;
      SEG_8:       nibble = 4'h8;
      SEG_9:       nibble = 4'h9;
      SEG_A_GLYPH: nibble = 4'hA;
      SEG_B_GLYPH: nibble = 4'hB;
      SEG_C_GLYPH: nibble = 4'hC;
      SEG_D_GLYPH: nibble = 4'hD;
      SEG_E_GLYPH: nibble = 4'hE;
      SEG_F_GLYPH: nibble = 4'hF;
      default:     bad    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mux_display_decoder.sv
// Receiver for a multiplexed 7-segment display bus. Registers the segment
// lines and one-hot digit select, waits for each digit phase to be stable,
// decodes it, and assembles a full NUM_DIGITS-digit hex frame.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   seg_in    - segments A..G on bits 0..6
//   dig_in    - one-hot digit select, bit0 = least significant nibble
//   value     - last completed frame, digit i in bits [4i+3:4i]
//   valid     - one-cycle pulse when value updates
//   pat_err   - held with value: some digit of that frame was undecodable
//   sel_err   - one-cycle pulse on a stable multi-hot select
//   seq_err   - one-cycle pulse on a digit captured out of rotation order
module mux_display_decoder
  import mux_display_decoder_pkg::*;
#(
  parameter int NUM_DIGITS     = DEFAULT_NUM_DIGITS,
  parameter int SETTLE_CYCLES  = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_in,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    valid,
  output logic                    pat_err,
  output logic                    sel_err,
  output logic                    seq_err
);

  localparam int                SAMPLE_W = 7 + NUM_DIGITS;
  localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0]        SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SAMPLE_W-1:0]     sample_reg, sample_next;
  logic [3:0]              count_reg, count_next;
  logic                    capture;
  logic [6:0]              cap_seg;
  logic [NUM_DIGITS-1:0]   cap_dig;
  logic [3:0]              cap_nibble;
  logic                    cap_bad;
  logic                    dig_blank, dig_multi, in_order, accept;
  logic [IDX_W-1:0]        cap_idx, expected_reg, expected_next;
  logic [NUM_DIGITS-1:0]   mask_reg, mask_next;
  logic                    bad_reg, bad_next;
  logic                    done_reg;
  logic [3:0]              nibble_reg [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] value_flat;
  logic [4*NUM_DIGITS-1:0] value_reg;
  logic                    valid_reg, pat_err_reg, sel_err_reg, seq_err_reg;

  // ---------------- input stage and stability counter ----------------
  assign sample_next = SEG_ACTIVE_LOW ? ~{seg_in, dig_in} : {seg_in, dig_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg <= '0;
      count_reg  <= '0;
    end else begin
      sample_reg <= sample_next;
      count_reg  <= count_next;
    end
  end

  // count_reg holds how many times in a row the current registered sample
  // has repeated, saturating so a long-held phase captures only once.
  always_comb begin
    count_next = 4'd0;
    if (sample_next == sample_reg) begin
      count_next = (count_reg >= SETTLE) ? SETTLE : count_reg + 4'd1;
    end
  end

  // Fires on the single edge where the count reaches SETTLE; the sample being
  // loaded equals sample_reg, so sample_reg is the captured content.
  assign capture = (sample_next == sample_reg) && (count_reg == SETTLE - 4'd1);

  assign cap_seg = sample_reg[SAMPLE_W-1:NUM_DIGITS];
  assign cap_dig = sample_reg[NUM_DIGITS-1:0];

  seg7_to_hex u_seg7_to_hex (
    .seg    (cap_seg),
    .nibble (cap_nibble),
    .bad    (cap_bad)
  );

  // ---------------- select classification and ordering ----------------
  always_comb begin
    dig_blank = (cap_dig == '0);
    dig_multi = ((cap_dig & (cap_dig - NUM_DIGITS'(1))) != '0);
    cap_idx   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (cap_dig[k]) cap_idx = IDX_W'(k);
    end
    in_order      = (cap_idx == expected_reg);
    accept        = capture && !dig_blank && !dig_multi;
    // An out-of-order digit restarts the frame with itself as first entry.
    mask_next     = in_order ? (mask_reg | cap_dig) : cap_dig;
    bad_next      = in_order ? (bad_reg | cap_bad) : cap_bad;
    expected_next = (cap_idx == LAST_IDX) ? '0 : cap_idx + IDX_W'(1);
  end

  // ---------------- per-digit nibble storage ----------------
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    always_ff @(posedge clk) begin
      if (rst) begin
        nibble_reg[gi] <= 4'h0;
      end else if (accept && cap_dig[gi]) begin
        nibble_reg[gi] <= cap_nibble;
      end
    end
    assign value_flat[4*gi +: 4] = nibble_reg[gi];
  end

  // ---------------- frame assembly and publishing ----------------
  // Captures are at least SETTLE_CYCLES apart, so the publish edge that
  // follows a completing capture never coincides with another capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg     <= '0;
      bad_reg      <= 1'b0;
      expected_reg <= '0;
      done_reg     <= 1'b0;
      value_reg    <= '0;
      valid_reg    <= 1'b0;
      pat_err_reg  <= 1'b0;
      sel_err_reg  <= 1'b0;
      seq_err_reg  <= 1'b0;
    end else begin
      valid_reg   <= done_reg;
      sel_err_reg <= capture && !dig_blank && dig_multi;
      seq_err_reg <= accept && !in_order;
      done_reg    <= accept && (mask_next == '1);
      if (done_reg) begin
        value_reg   <= value_flat;
        pat_err_reg <= bad_reg;
        mask_reg    <= '0;
        bad_reg     <= 1'b0;
      end else if (accept) begin
        mask_reg     <= mask_next;
        bad_reg      <= bad_next;
        expected_reg <= expected_next;
      end
    end
  end

  assign value   = value_reg;
  assign valid   = valid_reg;
  assign pat_err = pat_err_reg;
  assign sel_err = sel_err_reg;
  assign seq_err = seq_err_reg;

endmodule

// File: tb/tb_mux_display_decoder.sv
module tb_mux_display_decoder;

  localparam int N      = 4;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_in = '0;
  logic [15:0] value;
  logic        valid, pat_err, sel_err, seq_err;

  always #5 clk = ~clk;

  mux_display_decoder #(
    .NUM_DIGITS     (N),
    .SETTLE_CYCLES  (SETTLE),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .seg_in  (seg_in),
    .dig_in  (dig_in),
    .value   (value),
    .valid   (valid),
    .pat_err (pat_err),
    .sel_err (sel_err),
    .seq_err (seq_err)
  );

  int checks = 0;
  int errors = 0;

  // Output monitor, sampled mid-cycle
  int          valid_cnt = 0;
  int          sel_cnt   = 0;
  int          seq_cnt   = 0;
  logic [16:0] frame_q[$];  // {pat_err, value} per valid pulse

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        valid_cnt++;
        frame_q.push_back({pat_err, value});
      end
      if (sel_err) sel_cnt++;
      if (seq_err) seq_cnt++;
    end
  end

  // Glyph table for the reference model (index = hex value)
  logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [3:0] d, input int hold);
    seg_in = s;
    dig_in = d;
    tick(hold);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    seg_in = '0;
    dig_in = '0;
    tick(3);
    check("reset_state", {value, valid, pat_err, sel_err, seq_err}, 32'h0);
    rst = 1'b0;
    frame_q.delete();
  endtask

  // Phase encoding: 16'h{hold}{dig}{seg8}, e.g. 16'h414F = hold 4, dig 0001, seg 0x4F
  typedef struct {
    bit                rst_first;
    int                nph;
    logic [0:7][15:0]  ph;
    int                exp_valid;
    logic [15:0]       exp_value;
    logic              exp_pat;
    int                exp_sel;
    int                exp_seq;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  // Random-test storage
  logic [6:0]  r_seg[$];
  logic [3:0]  r_dig[$];
  int          r_hold[$];
  logic [16:0] exp_frames[$];

  initial begin
    int v0, s0, q0;
    int rot, ch, m_exp, m_sel, m_seq;
    int run_len;
    logic [6:0] run_seg;
    logic [3:0] run_dig;
    int          c_idx[$];
    logic [3:0]  c_nib[$];
    logic        c_bad[$];

    vecs[0] = '{rst_first:1, nph:4, ph:{16'h414F, 16'h425B, 16'h4406, 16'h483F, 64'h0},
                exp_valid:1, exp_value:16'h0123, exp_pat:0, exp_sel:0, exp_seq:0};
    vecs[1] = '{rst_first:1, nph:8, ph:{16'h114F, 16'h125B, 16'h1406, 16'h183F,
                                        16'h114F, 16'h125B, 16'h1406, 16'h183F},
                exp_valid:0, exp_value:16'h0000, exp_pat:0, exp_sel:0, exp_seq:0};
    vecs[2] = '{rst_first:1, nph:4, ph:{16'h4107, 16'h4207, 16'h4400, 16'h4807, 64'h0},
                exp_valid:1, exp_value:16'h7077, exp_pat:1, exp_sel:0, exp_seq:0};
    vecs[3] = '{rst_first:0, nph:4, ph:{16'h414F, 16'h425B, 16'h4406, 16'h483F, 64'h0},
                exp_valid:1, exp_value:16'h0123, exp_pat:0, exp_sel:0, exp_seq:0};
    vecs[4] = '{rst_first:1, nph:5, ph:{16'h434F, 16'h414F, 16'h425B, 16'h4406, 16'h483F, 48'h0},
                exp_valid:1, exp_value:16'h0123, exp_pat:0, exp_sel:1, exp_seq:0};
    vecs[5] = '{rst_first:1, nph:6, ph:{16'h4406, 16'h483F, 16'h414F, 16'h425B,
                                        16'h4406, 16'h483F, 32'h0},
                exp_valid:1, exp_value:16'h0123, exp_pat:0, exp_sel:0, exp_seq:1};
    vecs[6] = '{rst_first:1, nph:4, ph:{16'h314F, 16'h325B, 16'h3406, 16'h383F, 64'h0},
                exp_valid:1, exp_value:16'h0123, exp_pat:0, exp_sel:0, exp_seq:0};
    vecs[7] = '{rst_first:1, nph:4, ph:{16'h214F, 16'h225B, 16'h2406, 16'h283F, 64'h0},
                exp_valid:0, exp_value:16'h0000, exp_pat:0, exp_sel:0, exp_seq:0};
    vecs[8] = '{rst_first:1, nph:4, ph:{16'hF179, 16'hF25E, 16'hF439, 16'hF87C, 64'h0},
                exp_valid:1, exp_value:16'hBCDE, exp_pat:0, exp_sel:0, exp_seq:0};
    vecs[9] = '{rst_first:0, nph:4, ph:{16'h4171, 16'h427F, 16'h446F, 16'h4877, 64'h0},
                exp_valid:1, exp_value:16'hA98F, exp_pat:0, exp_sel:0, exp_seq:0};

    // ---------------- table-driven vectors ----------------
    for (int v = 0; v < NV; v++) begin
      if (vecs[v].rst_first) do_reset();
      v0 = valid_cnt; s0 = sel_cnt; q0 = seq_cnt;
      for (int p = 0; p < vecs[v].nph; p++) begin
        logic [15:0] ph;
        ph = vecs[v].ph[p];
        drive(ph[6:0], ph[11:8], int'(ph[15:12]));
      end
      drive(7'h00, 4'h0, 8);
      check($sformatf("vec%0d_valid_count", v), valid_cnt - v0, vecs[v].exp_valid);
      check($sformatf("vec%0d_value", v), value, vecs[v].exp_value);
      check($sformatf("vec%0d_pat_err", v), pat_err, vecs[v].exp_pat);
      check($sformatf("vec%0d_sel_err", v), sel_cnt - s0, vecs[v].exp_sel);
      check($sformatf("vec%0d_seq_err", v), seq_cnt - q0, vecs[v].exp_seq);
      $display("vec %0d: valids=%0d value=%h pat_err=%0d sel_errs=%0d seq_errs=%0d",
               v, valid_cnt - v0, value, pat_err, sel_cnt - s0, seq_cnt - q0);
    end

    // ---------------- latency and pulse width ----------------
    do_reset();
    drive(7'h4F, 4'b0001, 4);
    drive(7'h5B, 4'b0010, 4);
    drive(7'h06, 4'b0100, 4);
    drive(7'h3F, 4'b1000, 3);   // capture on 3rd edge, valid after the 4th
    check("latency_not_early", valid, 1'b0);
    tick(1);
    check("latency_valid", valid, 1'b1);
    check("latency_value", value, 16'h0123);
    tick(1);
    check("valid_one_cycle", valid, 1'b0);
    $display("latency seq: value=%h", value);
    drive(7'h00, 4'h0, 6);

    // ---------------- reset mid-frame ----------------
    do_reset();
    drive(7'h07, 4'b0001, 4);
    drive(7'h07, 4'b0010, 4);
    do_reset();
    v0 = valid_cnt; q0 = seq_cnt;
    drive(7'h4F, 4'b0001, 4);
    drive(7'h5B, 4'b0010, 4);
    drive(7'h06, 4'b0100, 4);
    drive(7'h3F, 4'b1000, 4);
    drive(7'h00, 4'h0, 8);
    check("midreset_valid_count", valid_cnt - v0, 1);
    check("midreset_seq_err", seq_cnt - q0, 0);
    check("midreset_value", value, 16'h0123);
    $display("mid-reset seq: valids=%0d value=%h", valid_cnt - v0, value);

    // ---------------- randomized run vs reference model ----------------
    do_reset();
    v0 = valid_cnt; s0 = sel_cnt; q0 = seq_cnt;
    rot = 0;
    for (int p = 0; p < 400; p++) begin
      logic [3:0] d;
      logic [6:0] s;
      int b0, b1;
      ch = $urandom_range(0, 9);
      if (ch == 0) d = 4'h0;
      else if (ch == 1) begin
        b0 = $urandom_range(0, 3);
        b1 = (b0 + $urandom_range(1, 3)) % 4;
        d = 4'h0;
        d[b0] = 1'b1;
        d[b1] = 1'b1;
      end else if (ch == 2) begin
        d = 4'h0;
        d[$urandom_range(0, 3)] = 1'b1;
      end else begin
        d = 4'h0;
        d[rot] = 1'b1;
        rot = (rot + 1) % N;
      end
      if ($urandom_range(0, 9) == 0) s = 7'($urandom_range(0, 127));
      else s = pat_tbl[$urandom_range(0, 15)];
      r_seg.push_back(s);
      r_dig.push_back(d);
      r_hold.push_back($urandom_range(1, 5));
    end
    r_seg.push_back(7'h00); r_dig.push_back(4'h0); r_hold.push_back(10);
    for (int p = 0; p < r_seg.size(); p++) drive(r_seg[p], r_dig[p], r_hold[p]);

    // Reference model: merge identical consecutive phases into runs; a run
    // lasting more than SETTLE cycles yields one stable digit event.
    m_exp = 0; m_sel = 0; m_seq = 0;
    run_seg = r_seg[0]; run_dig = r_dig[0]; run_len = 0;
    for (int p = 0; p <= r_seg.size(); p++) begin
      bit last;
      last = (p == r_seg.size());
      if (!last && r_seg[p] == run_seg && r_dig[p] == run_dig) begin
        run_len += r_hold[p];
      end else begin
        if (run_len >= SETTLE + 1 && run_dig != 4'h0) begin
          if ($countones(run_dig) > 1) m_sel++;
          else begin
            int idx, nib;
            idx = 0;
            for (int k = 0; k < N; k++) if (run_dig[k]) idx = k;
            nib = -1;
            for (int k = 0; k < 16; k++) if (pat_tbl[k] == run_seg) nib = k;
            if (idx != m_exp) begin
              m_seq++;
              c_idx.delete(); c_nib.delete(); c_bad.delete();
            end
            c_idx.push_back(idx);
            c_nib.push_back((nib < 0) ? 4'h0 : 4'(nib));
            c_bad.push_back(nib < 0);
            m_exp = (idx + 1) % N;
            if (c_idx.size() == N) begin
              logic [15:0] fv;
              logic fb;
              fv = '0; fb = 1'b0;
              for (int k = 0; k < N; k++) begin
                fv = fv | (16'(c_nib[k]) << (4 * c_idx[k]));
                fb = fb | c_bad[k];
              end
              exp_frames.push_back({fb, fv});
              c_idx.delete(); c_nib.delete(); c_bad.delete();
            end
          end
        end
        if (!last) begin
          run_seg = r_seg[p]; run_dig = r_dig[p]; run_len = r_hold[p];
        end
      end
    end

    check("rand_frame_count", frame_q.size(), exp_frames.size());
    check("rand_sel_err", sel_cnt - s0, m_sel);
    check("rand_seq_err", seq_cnt - q0, m_seq);
    for (int k = 0; k < exp_frames.size() && k < frame_q.size(); k++) begin
      check($sformatf("rand_frame%0d", k), frame_q[k], exp_frames[k]);
      $display("rand frame %0d: got pat_err=%0d value=%h expected pat_err=%0d value=%h",
               k, frame_q[k][16], frame_q[k][15:0], exp_frames[k][16], exp_frames[k][15:0]);
    end
    $display("random run: frames=%0d sel_errs=%0d seq_errs=%0d", frame_q.size(),
             sel_cnt - s0, seq_cnt - q0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
